// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding instruction-memory request at a
// time, buffers the response for decode, and handles branch/jump redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic grant;

  assign grant = imem_req && imem_gnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_valid) state_d = grant ? S_DROP : S_FETCH;
        else if (grant)     state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)         state_d = S_FETCH;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue only when the output buffer is empty or draining this edge, so a
  // response always finds room.
  always_comb begin
    imem_req  = (state_q == S_FETCH) && (!id_valid_q || id_ready);
    imem_addr = {pc_q[31:2], 2'b00};
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q && !id_ready;

    if (state_q == S_FETCH && grant) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end

    if (state_q == S_WAIT && imem_rvalid && !redirect_valid) begin
      id_instr_d = imem_rdata;
      id_pc_d    = req_pc_q;
      id_valid_d = 1'b1;
    end

    // Redirect wins over every other update, including a same-edge response.
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_opcode = id_instr_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-programmable memory responder plus a
// second instance with a top-of-memory reset address to exercise PC wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;

  logic        imem_req2, id_valid2, rvalid2;
  logic [31:0] imem_addr2, id_instr2, id_pc2;
  logic [6:0]  id_opcode2;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;
  int cnt   = 0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(32'h0000_0013),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid2), .id_ready(1'b1),
    .id_instr(id_instr2), .id_pc(id_pc2), .id_opcode(id_opcode2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[26:2], a[8:2] ^ 7'h33};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_held(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(id_valid), 32'd1);
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_instr"}, id_instr, instr_of(pc));
    check({tag, "_opcode"}, 32'(id_opcode), 32'(instr_of(pc) & 32'h7F));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_instr"}, id_instr, 32'd0);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_opcode"}, 32'(id_opcode), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_addr_top"}, imem_addr2, 32'hFFFF_FFFC);
  endtask

  // Memory responder: looks at the request just after each falling edge and
  // returns data `lat` rising edges after the grant edge.
  always begin
    @(negedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(pend_addr);
        end
      end
      if (imem_req && imem_gnt) begin
        cnt       = lat;
        pend_addr = imem_addr;
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    rvalid2        = 1'b0;

    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 check("idle_req", 32'(imem_req), 32'd0);

    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);
    check("top_first_addr", imem_addr2, 32'hFFFF_FFFC);

    tick();
    rvalid2 = 1'b1;

    // Zero-wait memory: one instruction every second cycle, pc 0, 4, 8.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stream_valid", 32'(id_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) check_held("stream", 32'(4 * (k / 2)));
      if (k == 0) begin
        check("top_wrap_req", 32'(imem_req2), 32'd1);
        check("top_wrap_addr", imem_addr2, 32'd0);
        rvalid2 = 1'b0;
      end
    end
    check("pre_stall_addr", imem_addr, 32'h0000_000C);

    // Decode back-pressure: buffer held, no request issued.
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_held("stall", 32'h8);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    tick();
    check("release_valid", 32'(id_valid), 32'd0);
    tick();
    check_held("after_stall", 32'hC);

    // Redirect while waiting on a slow response.
    lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    check("drop_req", 32'(imem_req), 32'd0);
    check("drop_valid", 32'(id_valid), 32'd0);
    tick();
    check("drop_req2", 32'(imem_req), 32'd0);
    tick();
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    tick();
    check("redir_valid0", 32'(id_valid), 32'd0);
    tick();
    check_held("redir", 32'h100);

    // Redirect on the same edge as a grant: owed response must be discarded.
    lat            = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("gdrop_req", 32'(imem_req), 32'd0);
    check("gdrop_valid", 32'(id_valid), 32'd0);
    tick();
    check("gdrop_req2", 32'(imem_req), 32'd0);
    tick();
    check("gdrop_fetch_req", 32'(imem_req), 32'd1);
    check("gdrop_fetch_addr", imem_addr, 32'h0000_0200);
    check("gdrop_stale", 32'(id_valid), 32'd0);
    lat = 1;
    tick();
    check("gdrop_valid0", 32'(id_valid), 32'd0);
    tick();
    check_held("gdrop", 32'h200);

    // Asynchronous reset with a request outstanding.
    tick();
    check("pre_rst_valid", 32'(id_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    tick();
    tick();
    check("rst_hold_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1 check("restart_idle_req", 32'(imem_req), 32'd0);
    tick();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, 32'd0);
    tick();
    check("restart_wait_req", 32'(imem_req), 32'd0);
    tick();
    check_held("restart", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
